pll_dcm_lock_sequencer: RTL and testbench
=========================================

// Module: pll_dcm_lock_sequencer
// PURPOSE
//  Sequences reset release of a cascaded PLL->DCM clock chain and supervises lock.
//  - Resets the PLL, waits for PLL lock, then resets the DCM and waits for DCM lock.
//  - Requires both locks stable for a hold period before asserting ready.
//  - Retries on timeout or lock loss; latches fault after MAX_RETRIES failures.
//  - Sits beside the plldcm chain, clocked from the free-running board oscillator.
// PARAMETERS
//  PLL_RESET_CYCLES     16     cycles pll_reset is held in PLL_RST (>=1)
//  DCM_RESET_CYCLES     16     cycles dcm_reset is held in DCM_RST (>=1)
//  LOCK_TIMEOUT_CYCLES  65535  max cycles in PLL_WAIT or DCM_WAIT before a retry
//  STABLE_CYCLES        256    consecutive both-locked cycles required before RUN
//  MAX_RETRIES          3      failed attempts tolerated; the next failure enters FAULT (1..15)
//  All cycle parameters are < 2**24; a shared 24-bit timer is used.
// PORTS
//  clock        in   1  free-running reference clock (not PLL/DCM derived)
//  reset_n      in   1  asynchronous, active-low reset
//  restart      in   1  sync pulse: abort and re-run the full sequence, clear retries
//  pll_locked   in   1  PLL LOCKED (async; 2-flop synchronised internally)
//  dcm_locked   in   1  DCM LOCKED (async; 2-flop synchronised internally)
//  pll_reset    out  1  active-high PLL RST
//  dcm_reset    out  1  active-high DCM RST
//  ready        out  1  chain locked and stable; downstream logic may run
//  fault        out  1  retries exhausted; sticky until restart or reset_n
//  retry_count  out  4  failed attempts since the last RUN, restart or reset
//  state        out  3  PLL_RST=0 PLL_WAIT=1 DCM_RST=2 DCM_WAIT=3 STABLE=4 RUN=5 FAULT=6
// BEHAVIOUR
//  Reset values: state=PLL_RST, pll_reset=1, dcm_reset=1, ready=0, fault=0, retry_count=0, timer=0.
//  Outputs are registered from the next state.
//  The lock inputs pass through 2-flop synchronisers; pl/dl below are the synchronised values.
//  The timer clears on every state change and otherwise increments.
//  PLL_RST:  pll_reset=1, dcm_reset=1. At timer==PLL_RESET_CYCLES-1 -> PLL_WAIT.
//  PLL_WAIT: pll_reset=0, dcm_reset=1.
//            pl=1 -> DCM_RST. timer==LOCK_TIMEOUT_CYCLES-1 -> FAIL.
//  DCM_RST:  dcm_reset=1. pl=0 -> FAIL. At timer==DCM_RESET_CYCLES-1 -> DCM_WAIT.
//  DCM_WAIT: dcm_reset=0. pl=0 -> FAIL. pl&dl -> STABLE.
//            timer==LOCK_TIMEOUT_CYCLES-1 -> FAIL.
//  STABLE:   any of pl,dl = 0 -> FAIL. At timer==STABLE_CYCLES-1 -> RUN.
//  RUN:      ready=1, retry_count cleared on entry.
//            Any lock drop -> PLL_RST (lock-loss event; not a FAIL, retry_count stays 0).
//            ready falls on the clock edge at which the drop is seen on pl/dl.
//  FAIL:     if retry_count==MAX_RETRIES -> FAULT; else retry_count+=1 and -> PLL_RST.
//  FAULT:    pll_reset=1, dcm_reset=1, fault=1, ready=0. Exits only on restart or reset_n.
//  Priority per cycle: restart > lock drop/timeout > normal advance.
//  restart in any state: -> PLL_RST, retry_count=0, fault=0.
//  Both locks dropping together is one event. Lock glitches shorter than one clock may be missed.
//  Async reset mid-sequence: all outputs take reset values immediately.
// CONFIGURATION
//  LOCK_LOSS_COUNTER_EN defined:
//    adds output lock_loss_count [7:0]: increments on each RUN->PLL_RST lock loss,
//    saturates at 255, cleared only by reset_n (restart does not clear it).
//  Not defined: the port is absent and no counter logic is built.
// TESTING
//  1 Locks rise 10 cycles after each reset release:
//    PLL_RST 16 cyc -> PLL_WAIT -> DCM_RST 16 cyc -> DCM_WAIT -> STABLE 256 cyc -> RUN,
//    ready=1, retry_count=0.
//  2 pll_locked never rises, MAX_RETRIES=3: three timeouts (retry_count 1,2,3),
//    4th timeout -> FAULT, fault=1, both resets=1.
//  3 In RUN, dcm_locked low 5 cycles: ready=0 within 3 clocks of the drop (2 sync + 1),
//    -> PLL_RST, re-lock reaches RUN; lock_loss_count=1 when the macro is defined.
//  4 dcm_locked glitches low at cycle 100 of STABLE: retry_count=1, -> PLL_RST, ready stays 0.
//  5 restart pulse while in FAULT and while in DCM_WAIT: next state PLL_RST,
//    fault=0, retry_count=0.
//  6 reset_n asserted mid-STABLE: outputs immediately at reset values;
//    release restarts from PLL_RST.

Source files
------------

// File: rtl/pll_dcm_lock_sequencer.sv
// pll_dcm_lock_sequencer
// Releases a cascaded PLL->DCM clock chain from reset in order and supervises lock.
// The PLL is reset and given time to lock, then the DCM is reset and given time to lock.
// Both locks must then hold for STABLE_CYCLES before ready asserts. A timeout or lock
// drop during bring-up counts as a failed attempt. Failed attempts are retried until
// MAX_RETRIES is exhausted, after which fault latches.
// Optional build macro LOCK_LOSS_COUNTER_EN adds lock_loss_count, a saturating count
// of lock losses seen while running.
module pll_dcm_lock_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned DCM_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
    parameter int unsigned STABLE_CYCLES       = 256,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       restart,
    input  logic       pll_locked,
    input  logic       dcm_locked,
    output logic       pll_reset,
    output logic       dcm_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] state
`ifdef LOCK_LOSS_COUNTER_EN
    ,
    output logic [7:0] lock_loss_count
`endif
);

    typedef enum logic [2:0] {
        StPllRst  = 3'd0,
        StPllWait = 3'd1,
        StDcmRst  = 3'd2,
        StDcmWait = 3'd3,
        StStable  = 3'd4,
        StRun     = 3'd5,
        StFault   = 3'd6
    } state_e;

    // Timer values on the last cycle allowed in each timed state.
    localparam logic [23:0] PllRstLast  = 24'(PLL_RESET_CYCLES - 1);
    localparam logic [23:0] DcmRstLast  = 24'(DCM_RESET_CYCLES - 1);
    localparam logic [23:0] TimeoutLast = 24'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [23:0] StableLast  = 24'(STABLE_CYCLES - 1);
    localparam logic [3:0]  MaxRetries  = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [1:0]  pll_sync_q, dcm_sync_q;
    logic        pll_reset_q, pll_reset_d;
    logic        dcm_reset_q, dcm_reset_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        attempt_failed;
    logic        pl, dl;

    assign pl = pll_sync_q[1];
    assign dl = dcm_sync_q[1];

    // Two-flop synchronisers for the asynchronous lock indicators.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pll_sync_q <= 2'b00;
            dcm_sync_q <= 2'b00;
        end else begin
            pll_sync_q <= {pll_sync_q[0], pll_locked};
            dcm_sync_q <= {dcm_sync_q[0], dcm_locked};
        end
    end

    // Sequencer state, shared timer, retry counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StPllRst;
            timer_q     <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            dcm_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            dcm_reset_q <= dcm_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    // Next state: restart first, then lock drop/timeout, then normal advance.
    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        attempt_failed = 1'b0;
        if (restart) begin
            state_d = StPllRst;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (timer_q == PllRstLast) state_d = StPllWait;
                end
                StPllWait: begin
                    if (timer_q == TimeoutLast) attempt_failed = 1'b1;
                    else if (pl)                state_d = StDcmRst;
                end
                StDcmRst: begin
                    if (!pl)                         attempt_failed = 1'b1;
                    else if (timer_q == DcmRstLast)  state_d = StDcmWait;
                end
                StDcmWait: begin
                    if (!pl || timer_q == TimeoutLast) attempt_failed = 1'b1;
                    else if (dl)                       state_d = StStable;
                end
                StStable: begin
                    if (!(pl && dl))                attempt_failed = 1'b1;
                    else if (timer_q == StableLast) state_d = StRun;
                end
                StRun: begin
                    // Lock loss while running restarts bring-up without costing a retry.
                    if (!(pl && dl)) state_d = StPllRst;
                end
                StFault: begin
                    state_d = StFault;
                end
                default: state_d = StPllRst;
            endcase

            if (attempt_failed) begin
                if (retry_q == MaxRetries) begin
                    state_d = StFault;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = StPllRst;
                end
            end

            if (state_d == StRun && state_q != StRun) retry_d = '0;
        end

        timer_d = (restart || state_d != state_q) ? '0 : timer_q + 24'd1;
    end

    // Output decode from the next state so outputs change with the state register.
    always_comb begin
        pll_reset_d = 1'b0;
        dcm_reset_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        unique case (state_d)
            StPllRst: begin
                pll_reset_d = 1'b1;
                dcm_reset_d = 1'b1;
            end
            StPllWait, StDcmRst: begin
                dcm_reset_d = 1'b1;
            end
            StRun: begin
                ready_d = 1'b1;
            end
            StFault: begin
                pll_reset_d = 1'b1;
                dcm_reset_d = 1'b1;
                fault_d     = 1'b1;
            end
            default: begin
                pll_reset_d = 1'b0;
            end
        endcase
    end

`ifdef LOCK_LOSS_COUNTER_EN
    logic [7:0] loss_q;

    // Saturating count of RUN lock losses; only reset_n clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if (!restart && state_q == StRun && state_d == StPllRst && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_q;
`endif

    assign pll_reset   = pll_reset_q;
    assign dcm_reset   = dcm_reset_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_dcm_lock_sequencer.sv
// Testbench for pll_dcm_lock_sequencer: a fixed vector table for the nominal bring-up
// and a RUN lock loss, hand sequences for timeouts, restart, STABLE glitch and async
// reset, then randomized lock/restart traffic, all shadowed by a reference model.
module tb_pll_dcm_lock_sequencer;

    localparam int PR = 16;
    localparam int DR = 16;
    localparam int TO = 200;
    localparam int ST = 256;
    localparam int MR = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       restart = 1'b0;
    logic       pll_locked = 1'b0;
    logic       dcm_locked = 1'b0;
    logic       pll_reset, dcm_reset, ready, fault;
    logic [3:0] retry_count;
    logic [2:0] state;
`ifdef LOCK_LOSS_COUNTER_EN
    logic [7:0] lock_loss_count;
`endif

    int tests = 0;
    int fails = 0;

    pll_dcm_lock_sequencer #(
        .PLL_RESET_CYCLES   (PR),
        .DCM_RESET_CYCLES   (DR),
        .LOCK_TIMEOUT_CYCLES(TO),
        .STABLE_CYCLES      (ST),
        .MAX_RETRIES        (MR)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .restart    (restart),
        .pll_locked (pll_locked),
        .dcm_locked (dcm_locked),
        .pll_reset  (pll_reset),
        .dcm_reset  (dcm_reset),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .state      (state)
`ifdef LOCK_LOSS_COUNTER_EN
        ,
        .lock_loss_count(lock_loss_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: phase numbers are the externally visible state codes.
    // Each timed phase has a length; the phase's output levels come from lookup tables.
    int phase_len  [0:6] = '{PR, TO, DR, TO, ST, 0, 0};
    int phase_pllr [0:6] = '{1, 0, 0, 0, 0, 0, 1};
    int phase_dcmr [0:6] = '{1, 1, 1, 0, 0, 0, 1};
    int m_phase, m_elapsed, m_tries, m_losses;
    bit pll_hist[$];
    bit dcm_hist[$];

    function automatic void model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_tries   = 0;
        m_losses  = 0;
        pll_hist  = '{1'b0, 1'b0};
        dcm_hist  = '{1'b0, 1'b0};
    endfunction

    function automatic void model_step();
        bit pl, dl, last, failed;
        int nxt;
        // Synchronised view is the raw sample taken two edges earlier.
        pl = pll_hist.pop_front();
        dl = dcm_hist.pop_front();
        pll_hist.push_back(pll_locked);
        dcm_hist.push_back(dcm_locked);
        last   = (m_elapsed + 1 == phase_len[m_phase]);
        failed = 1'b0;
        nxt    = m_phase;
        if (restart) begin
            nxt     = 0;
            m_tries = 0;
        end else begin
            if (m_phase == 0 && last) nxt = 1;
            if (m_phase == 1) begin
                if (last) failed = 1'b1; else if (pl) nxt = 2;
            end
            if (m_phase == 2) begin
                if (!pl) failed = 1'b1; else if (last) nxt = 3;
            end
            if (m_phase == 3) begin
                if (!pl || last) failed = 1'b1; else if (dl) nxt = 4;
            end
            if (m_phase == 4) begin
                if (!(pl && dl)) failed = 1'b1; else if (last) nxt = 5;
            end
            if (m_phase == 5 && !(pl && dl)) begin
                nxt = 0;
                m_losses = (m_losses < 255) ? m_losses + 1 : 255;
            end
            if (failed) begin
                if (m_tries >= MR) nxt = 6;
                else begin
                    m_tries++;
                    nxt = 0;
                end
            end
            if (nxt == 5 && m_phase != 5) m_tries = 0;
        end
        m_elapsed = (restart || nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model state", int'(state), m_phase);
        chk("model pll_reset", int'(pll_reset), phase_pllr[m_phase]);
        chk("model dcm_reset", int'(dcm_reset), phase_dcmr[m_phase]);
        chk("model ready", int'(ready), int'(m_phase == 5));
        chk("model fault", int'(fault), int'(m_phase == 6));
        chk("model retry_count", int'(retry_count), m_tries);
`ifdef LOCK_LOSS_COUNTER_EN
        chk("model lock_loss_count", int'(lock_loss_count), m_losses);
`endif
    endtask

    // One clock: advance the model on pre-edge inputs, then sample the DUT after the edge.
    task automatic tick();
        if (!reset_n) model_reset();
        else          model_step();
        @(posedge clock);
        #1;
        compare_model();
    endtask

    task automatic run_until(input int target, input int budget, input string name,
                             output int n);
        n = 0;
        while (int'(state) != target && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (int'(state) != target) begin
            fails++;
            $display("FAIL %s: state %0d after %0d cycles, required %0d", name, state, n,
                     target);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    typedef struct {
        logic       p;
        logic       d;
        int         n;
        int         st;
        logic       pr;
        logic       dr;
        logic       rdy;
        int         rc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic p, input logic d, input int n, input int st,
                                input logic pr, input logic dr, input logic rdy, input int rc);
        vec_t v;
        v.p = p; v.d = d; v.n = n; v.st = st;
        v.pr = pr; v.dr = dr; v.rdy = rdy; v.rc = rc;
        vecs.push_back(v);
    endfunction

    initial begin
        int n;

        // Nominal bring-up, then a 5-cycle DCM drop in RUN and re-lock.
        add(0, 0, 15,  0, 1, 1, 0, 0);
        add(0, 0, 1,   1, 0, 1, 0, 0);
        add(0, 0, 9,   1, 0, 1, 0, 0);
        add(1, 0, 2,   1, 0, 1, 0, 0);
        add(1, 0, 1,   2, 0, 1, 0, 0);
        add(1, 0, 15,  2, 0, 1, 0, 0);
        add(1, 0, 1,   3, 0, 0, 0, 0);
        add(1, 1, 2,   3, 0, 0, 0, 0);
        add(1, 1, 1,   4, 0, 0, 0, 0);
        add(1, 1, 255, 4, 0, 0, 0, 0);
        add(1, 1, 1,   5, 0, 0, 1, 0);
        add(1, 1, 20,  5, 0, 0, 1, 0);
        add(1, 0, 2,   5, 0, 0, 1, 0);
        add(1, 0, 1,   0, 1, 1, 0, 0);
        add(1, 0, 2,   0, 1, 1, 0, 0);
        add(1, 1, 13,  0, 1, 1, 0, 0);
        add(1, 1, 1,   1, 0, 1, 0, 0);
        add(1, 1, 1,   2, 0, 1, 0, 0);
        add(1, 1, 16,  3, 0, 0, 0, 0);
        add(1, 1, 1,   4, 0, 0, 0, 0);
        add(1, 1, 256, 5, 0, 0, 1, 0);

        // Power-on reset.
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset state", int'(state), 0);
        chk("reset pll_reset", int'(pll_reset), 1);
        chk("reset dcm_reset", int'(dcm_reset), 1);
        chk("reset ready", int'(ready), 0);
        chk("reset fault", int'(fault), 0);
        chk("reset retry_count", int'(retry_count), 0);
        tick();
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            pll_locked = vecs[i].p;
            dcm_locked = vecs[i].d;
            repeat (vecs[i].n) tick();
            chk($sformatf("vec%0d state", i), int'(state), vecs[i].st);
            chk($sformatf("vec%0d pll_reset", i), int'(pll_reset), int'(vecs[i].pr));
            chk($sformatf("vec%0d dcm_reset", i), int'(dcm_reset), int'(vecs[i].dr));
            chk($sformatf("vec%0d ready", i), int'(ready), int'(vecs[i].rdy));
            chk($sformatf("vec%0d retry_count", i), int'(retry_count), vecs[i].rc);
        end
`ifdef LOCK_LOSS_COUNTER_EN
        chk("lock_loss_count after drop", int'(lock_loss_count), 1);
`endif

        // PLL never locks: three retried timeouts, the fourth latches fault.
        pll_locked = 1'b0;
        dcm_locked = 1'b0;
        pulse_restart();
        for (int k = 1; k <= MR; k++) begin
            run_until(1, PR + 2, "reach PLL_WAIT", n);
            run_until(0, TO + 2, "PLL_WAIT timeout", n);
            chk("timeout length", n, TO);
            chk("retry after timeout", int'(retry_count), k);
        end
        run_until(1, PR + 2, "reach PLL_WAIT", n);
        run_until(6, TO + 2, "reach FAULT", n);
        chk("fault flag", int'(fault), 1);
        chk("fault pll_reset", int'(pll_reset), 1);
        chk("fault dcm_reset", int'(dcm_reset), 1);
        chk("fault retry_count", int'(retry_count), MR);
        repeat (20) tick();
        chk("fault is sticky", int'(state), 6);

        // Restart from FAULT.
        pulse_restart();
        chk("restart in FAULT state", int'(state), 0);
        chk("restart in FAULT fault", int'(fault), 0);
        chk("restart in FAULT retry", int'(retry_count), 0);

        // DCM never locks: one timeout in DCM_WAIT, then restart from DCM_WAIT.
        pll_locked = 1'b1;
        run_until(3, PR + DR + 10, "reach DCM_WAIT", n);
        run_until(0, TO + 2, "DCM_WAIT timeout", n);
        chk("DCM timeout retry", int'(retry_count), 1);
        run_until(3, PR + DR + 10, "reach DCM_WAIT again", n);
        pulse_restart();
        chk("restart in DCM_WAIT state", int'(state), 0);
        chk("restart in DCM_WAIT retry", int'(retry_count), 0);

        // One-cycle DCM glitch at cycle 100 of STABLE.
        dcm_locked = 1'b1;
        run_until(4, PR + DR + 10, "reach STABLE", n);
        repeat (99) tick();
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        run_until(0, 4, "STABLE glitch abort", n);
        chk("glitch retry_count", int'(retry_count), 1);
        chk("glitch ready", int'(ready), 0);

        // Async reset in the middle of STABLE.
        run_until(4, PR + DR + 10, "reach STABLE for reset", n);
        repeat (50) tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async reset state", int'(state), 0);
        chk("async reset pll_reset", int'(pll_reset), 1);
        chk("async reset dcm_reset", int'(dcm_reset), 1);
        chk("async reset ready", int'(ready), 0);
        chk("async reset retry", int'(retry_count), 1 - 1);
        tick();
        tick();
        reset_n = 1'b1;
        run_until(5, PR + DR + ST + 20, "re-run to RUN after reset", n);
        chk("RUN after reset ready", int'(ready), 1);

        // Random lock behaviour and occasional restarts.
        for (int ep = 0; ep < 12; ep++) begin
            int pp, pd;
            case ($urandom_range(3))
                0: pp = 0;
                1: pp = 99;
                default: pp = 100;
            endcase
            case ($urandom_range(3))
                0: pd = 0;
                1: pd = 99;
                default: pd = 100;
            endcase
            pulse_restart();
            for (int c = 0; c < 700; c++) begin
                pll_locked = ($urandom_range(99) < pp);
                dcm_locked = ($urandom_range(99) < pd);
                restart    = ($urandom_range(499) == 0);
                tick();
            end
            restart = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
